pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
//  Detects load-use hazards, branch/jump redirects, multi-cycle data-memory waits and exceptions/IRQs.
//  Drives write-enable, hold and clear to every pipeline register and PC, plus the PC-source select.
//  Owns a 3-state FSM and a memory-timeout counter; sits beside the ID stage in the CPU top level.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles in MEM_WAIT before a bus-error exception is raised (range 2..255)
//  CNT_W        8   width of the timeout counter; must be wide enough to hold MEM_TIMEOUT
// PORTS
//  clk            in   1  system clock; all state updates on the rising edge
//  reset          in   1  synchronous, active-high reset
//  id_rs, id_rt   in   5  source registers of the instruction in ID
//  id_uses_rs/rt  in   1  ID instruction reads rs/rt
//  ex_memread     in   1  instruction in EX is a load
//  ex_wreg        in   5  destination register of the EX instruction
//  ex_branch_tk   in   1  branch resolved taken in EX
//  id_jump        in   1  jump decoded in ID
//  mem_req        in   1  MEM-stage instruction accesses data memory
//  mem_ready      in   1  data memory completes the access this cycle
//  exc_ex         in   1  EX-stage exception (overflow, illegal op)
//  irq            in   1  external interrupt, level-sensitive
//  pc_write       out  1  PC load enable
//  ifid_write     out  1  IF/ID load enable
//  pipe_hold      out  1  freeze ID/EX and EX/MEM (no load)
//  ifid_clear, idex_clear, exmem_clear, memwb_clear  out 1 each  synchronous bubble insert
//  pc_sel         out  2  00 PC+4, 01 branch/jump target, 10 exception vector
//  epc_write      out  1  capture EX PC into EPC
//  bus_err        out  1  1-cycle pulse on memory timeout
// BEHAVIOUR
//  Outputs are combinational from (state, inputs); state and counter are registered.
//  While reset=1: pc_write=ifid_write=0, pipe_hold=0, all four clears=1, pc_sel=00,
//    epc_write=bus_err=0. After reset: state RUN, counter 0.
//  Idle defaults (RUN, no event): pc_write=ifid_write=1, every other output 0.
//  States: RUN, MEM_WAIT, EXC_FLUSH. Event priority in RUN (highest first):
//   1 exception (exc_ex | irq): epc_write=1, pc_sel=10, ifid_clear=idex_clear=exmem_clear=1;
//     -> EXC_FLUSH.
//   2 mem_req & ~mem_ready: pc_write=ifid_write=0, pipe_hold=1, memwb_clear=1;
//     counter<=1; -> MEM_WAIT.
//   3 ex_branch_tk: pc_sel=01, ifid_clear=idex_clear=1.
//   4 id_jump: pc_sel=01, ifid_clear=1.
//   5 load-use (ex_memread & ex_wreg!=0 & ((id_uses_rs & rs==ex_wreg) | (id_uses_rt & rt==ex_wreg))):
//     pc_write=ifid_write=0, idex_clear=1 (exactly one bubble per hazard).
//  Branch and jump in the same cycle: branch wins (older instruction).
//  MEM_WAIT: pc_write=ifid_write=0, pipe_hold=1, memwb_clear=1; irq ignored (stays pending).
//   mem_ready=1 -> RUN, counter<=0; released cycle uses the RUN rules.
//   counter==MEM_TIMEOUT with mem_ready=0: bus_err=1, epc_write=1, pc_sel=10,
//     exmem_clear=idex_clear=ifid_clear=1, counter<=0; -> EXC_FLUSH.
//   mem_ready and timeout in the same cycle: mem_ready wins, no bus_err.
//  EXC_FLUSH (exactly 1 cycle): ifid_clear=1, pc_write=1, irq masked; -> RUN.
//  Reset asserted in any state: -> RUN next edge, counter cleared, no bus_err.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//    stall_cnt +1 per cycle with pc_write=0; flush_cnt +1 per cycle with ifid_clear=1 (reset excluded).
//    Both saturate at 2^32-1 and are zeroed by reset.
//  HAZ_PERF_CNT_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pipe_pkg: state encodings (RUN=0, MEM_WAIT=1, EXC_FLUSH=2),
//    PC_SEL_SEQ/BR/EXC constants.
//  Sub-module hazard_perf_counter (saturating 32-bit counter, inc enable), instantiated twice
//    under HAZ_PERF_CNT_EN. All other logic stays flat in this module.
// TESTING
//  Load-use: ex_memread=1, ex_wreg=5, id_rs=5, id_uses_rs=1 -> one cycle pc_write=0, idex_clear=1,
//    then the next cycle is normal.
//  $zero: same as load-use but ex_wreg=0, id_rs=0 -> no stall.
//  Branch+jump same cycle: ex_branch_tk=1, id_jump=1 -> pc_sel=01, ifid_clear=idex_clear=1.
//  Mem wait: mem_req=1, mem_ready low for 3 cycles -> pipe_hold=1 for 4 cycles, memwb_clear=1;
//    returns to RUN; irq asserted mid-wait is taken only after release.
//  Timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> bus_err pulse on the 5th cycle, pc_sel=10,
//    then EXC_FLUSH for 1 cycle, then RUN.
//  Reset in MEM_WAIT: reset=1 for 1 cycle -> all clears=1 during reset; RUN afterwards;
//    no bus_err; perf counters (if enabled) read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the MIPS pipeline hazard sequencer:
// FSM state encodings, PC-source selects and the load-use detector.
package mips_pipe_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MEM_WAIT  = 2'd1,
      EXC_FLUSH = 2'd2
   } haz_state_e;

   localparam logic [1:0] PC_SEL_SEQ = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_EXC = 2'b10;

   function automatic logic load_use(
      input logic       memread,
      input logic [4:0] wreg,
      input logic       uses_rs,
      input logic [4:0] rs,
      input logic       uses_rt,
      input logic [4:0] rt
   );
      // $zero is never a real dependency
      return memread && (wreg != 5'd0) &&
             ((uses_rs && rs == wreg) || (uses_rt && rt == wreg));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush controls back to it.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       ex_memread;
   logic [4:0] ex_wreg;
   logic       ex_branch_tk;
   logic       id_jump;
   logic       mem_req;
   logic       mem_ready;
   logic       exc_ex;
   logic       irq;

   logic       pc_write;
   logic       ifid_write;
   logic       pipe_hold;
   logic       ifid_clear;
   logic       idex_clear;
   logic       exmem_clear;
   logic       memwb_clear;
   logic [1:0] pc_sel;
   logic       epc_write;
   logic       bus_err;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wreg,
             ex_branch_tk, id_jump, mem_req, mem_ready, exc_ex, irq,
      input  pc_write, ifid_write, pipe_hold, ifid_clear, idex_clear,
             exmem_clear, memwb_clear, pc_sel, epc_write, bus_err
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_wreg,
             ex_branch_tk, id_jump, mem_req, mem_ready, exc_ex, irq,
      output pc_write, ifid_write, pipe_hold, ifid_clear, idex_clear,
             exmem_clear, memwb_clear, pc_sel, epc_write, bus_err
   );
endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating 32-bit event counter with synchronous active-high clear.
module hazard_perf_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [31:0] cnt
);
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && cnt_q != 32'hFFFF_FFFF)
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Define HAZ_PERF_CNT_EN to add stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

   haz_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exc, lu;

   assign exc = hz.exc_ex | hz.irq;
   assign lu  = load_use(hz.ex_memread, hz.ex_wreg, hz.id_uses_rs,
                         hz.id_rs, hz.id_uses_rt, hz.id_rt);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.pipe_hold   = 1'b0;
      hz.ifid_clear  = 1'b0;
      hz.idex_clear  = 1'b0;
      hz.exmem_clear = 1'b0;
      hz.memwb_clear = 1'b0;
      hz.pc_sel      = PC_SEL_SEQ;
      hz.epc_write   = 1'b0;
      hz.bus_err     = 1'b0;
      unique case (state_q)
         RUN: begin
            if (exc) begin
               hz.epc_write   = 1'b1;
               hz.pc_sel      = PC_SEL_EXC;
               hz.ifid_clear  = 1'b1;
               hz.idex_clear  = 1'b1;
               hz.exmem_clear = 1'b1;
               state_d        = EXC_FLUSH;
            end else if (hz.mem_req && !hz.mem_ready) begin
               hz.pc_write    = 1'b0;
               hz.ifid_write  = 1'b0;
               hz.pipe_hold   = 1'b1;
               hz.memwb_clear = 1'b1;
               cnt_d          = CNT_W'(1);
               state_d        = MEM_WAIT;
            end else if (hz.ex_branch_tk) begin
               hz.pc_sel     = PC_SEL_BR;
               hz.ifid_clear = 1'b1;
               hz.idex_clear = 1'b1;
            end else if (hz.id_jump) begin
               hz.pc_sel     = PC_SEL_BR;
               hz.ifid_clear = 1'b1;
            end else if (lu) begin
               hz.pc_write   = 1'b0;
               hz.ifid_write = 1'b0;
               hz.idex_clear = 1'b1;
            end
         end
         MEM_WAIT: begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.pipe_hold   = 1'b1;
            hz.memwb_clear = 1'b1;
            if (hz.mem_ready) begin
               cnt_d   = '0;
               state_d = RUN;
            end else if (cnt_q == TMO) begin
               // the pipe must move to fetch the vector
               hz.pc_write    = 1'b1;
               hz.ifid_write  = 1'b1;
               hz.pipe_hold   = 1'b0;
               hz.bus_err     = 1'b1;
               hz.epc_write   = 1'b1;
               hz.pc_sel      = PC_SEL_EXC;
               hz.ifid_clear  = 1'b1;
               hz.idex_clear  = 1'b1;
               hz.exmem_clear = 1'b1;
               cnt_d          = '0;
               state_d        = EXC_FLUSH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         EXC_FLUSH: begin
            hz.ifid_clear = 1'b1;
            state_d       = RUN;
         end
         default: state_d = RUN;
      endcase
      if (reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.pipe_hold   = 1'b0;
         hz.ifid_clear  = 1'b1;
         hz.idex_clear  = 1'b1;
         hz.exmem_clear = 1'b1;
         hz.memwb_clear = 1'b1;
         hz.pc_sel      = PC_SEL_SEQ;
         hz.epc_write   = 1'b0;
         hz.bus_err     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   hazard_perf_counter u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (!reset && !hz.pc_write),
      .cnt   (stall_cnt)
   );

   hazard_perf_counter u_flush (
      .clk   (clk),
      .reset (reset),
      .inc   (!reset && hz.ifid_clear),
      .cnt   (flush_cnt)
   );
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Expected control vectors come from a behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if hz ();

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   typedef struct {
      string      tag;
      logic [10:0] v;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  errors = 0;
   int  m_st   = 0;
   int  m_cnt  = 0;
   longint m_stall = 0;
   longint m_flush = 0;
   string cur_tag = "init";

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {pc_write,ifid_write,pipe_hold,ifid_clear,idex_clear,
   //  exmem_clear,memwb_clear,pc_sel[1:0],epc_write,bus_err}
   function automatic logic [10:0] dut_vec();
      return {hz.pc_write, hz.ifid_write, hz.pipe_hold, hz.ifid_clear,
              hz.idex_clear, hz.exmem_clear, hz.memwb_clear, hz.pc_sel,
              hz.epc_write, hz.bus_err};
   endfunction

   task automatic model(output logic [10:0] v, output int nst,
                        output int ncnt);
      logic pw, iw, ph, ic, xc, mc, wc, ep, be;
      logic [1:0] ps;
      logic hazard;
      pw = 1; iw = 1; ph = 0; ic = 0; xc = 0; mc = 0; wc = 0;
      ep = 0; be = 0; ps = 2'b00;
      nst = m_st; ncnt = m_cnt;
      hazard = 0;
      if (hz.ex_memread && hz.ex_wreg != 0) begin
         if (hz.id_uses_rs && hz.id_rs == hz.ex_wreg) hazard = 1;
         if (hz.id_uses_rt && hz.id_rt == hz.ex_wreg) hazard = 1;
      end
      if (m_st == 0) begin
         if (hz.exc_ex || hz.irq) begin
            ep = 1; ps = 2'b10; ic = 1; xc = 1; mc = 1; nst = 2;
         end else if (hz.mem_req && !hz.mem_ready) begin
            pw = 0; iw = 0; ph = 1; wc = 1; ncnt = 1; nst = 1;
         end else if (hz.ex_branch_tk) begin
            ps = 2'b01; ic = 1; xc = 1;
         end else if (hz.id_jump) begin
            ps = 2'b01; ic = 1;
         end else if (hazard) begin
            pw = 0; iw = 0; xc = 1;
         end
      end else if (m_st == 1) begin
         wc = 1;
         if (hz.mem_ready) begin
            pw = 0; iw = 0; ph = 1; ncnt = 0; nst = 0;
         end else if (m_cnt == TMO) begin
            be = 1; ep = 1; ps = 2'b10; ic = 1; xc = 1; mc = 1;
            ncnt = 0; nst = 2;
         end else begin
            pw = 0; iw = 0; ph = 1; ncnt = m_cnt + 1;
         end
      end else begin
         ic = 1; nst = 0;
      end
      if (reset) begin
         pw = 0; iw = 0; ph = 0; ic = 1; xc = 1; mc = 1; wc = 1;
         ps = 2'b00; ep = 0; be = 0; nst = 0; ncnt = 0;
      end
      v = {pw, iw, ph, ic, xc, mc, wc, ps, ep, be};
   endtask

   task automatic idle();
      reset = 0;
      hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
      hz.ex_memread = 0; hz.ex_wreg = 0; hz.ex_branch_tk = 0;
      hz.id_jump = 0; hz.mem_req = 0; hz.mem_ready = 0;
      hz.exc_ex = 0; hz.irq = 0;
   endtask

   // Inputs are already driven (posedge+1); check at negedge, then clock.
   task automatic step(input string tag);
      logic [10:0] ev;
      int nst, ncnt;
      sb_t e;
      model(ev, nst, ncnt);
      sb_q.push_back('{tag, ev});
      #4;
      e = sb_q.pop_front();
      chk(e.tag, {21'd0, dut_vec()}, {21'd0, e.v});
      if (!reset) begin
         if (!ev[10] && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (ev[7] && m_flush < 64'hFFFF_FFFF) m_flush++;
      end else begin
         m_stall = 0;
         m_flush = 0;
      end
      m_st = nst;
      m_cnt = ncnt;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_perf(input string tag);
`ifdef HAZ_PERF_CNT_EN
      chk({tag, "_stall"}, stall_cnt, 32'(m_stall));
      chk({tag, "_flush"}, flush_cnt, 32'(m_flush));
`else
      cur_tag = tag;
`endif
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      #1;
      step("rst0");
      step("rst1");
      idle();
      chk_perf("rst_perf");
      step("idle");

      hz.ex_memread = 1; hz.ex_wreg = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
      step("lu_rs");
      idle();
      step("lu_after");
      hz.ex_memread = 1; hz.ex_wreg = 7; hz.id_rt = 7; hz.id_uses_rt = 1;
      step("lu_rt");
      hz.id_uses_rt = 0; hz.id_rs = 7;
      step("lu_nouse");
      hz.ex_wreg = 0; hz.id_rs = 0; hz.id_uses_rs = 1;
      step("lu_zero");
      idle();

      hz.ex_branch_tk = 1; hz.id_jump = 1;
      step("br_jmp");
      hz.ex_branch_tk = 0;
      step("jmp");
      hz.ex_memread = 1; hz.ex_wreg = 3; hz.id_rs = 3; hz.id_uses_rs = 1;
      step("jmp_lu");
      idle();
      hz.exc_ex = 1; hz.ex_branch_tk = 1;
      step("exc_br");
      idle();
      step("exc_flush");
      step("exc_run");

      hz.mem_req = 1;
      step("mw0");
      hz.irq = 1;
      step("mw1_irq");
      step("mw2_irq");
      hz.mem_ready = 1;
      step("mw_rdy");
      hz.mem_req = 0; hz.mem_ready = 0;
      step("irq_take");
      step("irq_mask");
      idle();
      step("irq_run");

      hz.mem_req = 1;
      for (int i = 0; i < 5; i++) step($sformatf("tmo%0d", i));
      idle();
      step("tmo_flush");
      step("tmo_run");

      hz.mem_req = 1;
      for (int i = 0; i < 4; i++) step($sformatf("race%0d", i));
      hz.mem_ready = 1;
      step("race_rdy");
      idle();
      step("race_run");

      hz.mem_req = 1;
      step("rw0");
      step("rw1");
      reset = 1;
      step("rw_rst");
      idle();
      chk_perf("rw_perf");
      step("rw_run");
      hz.mem_req = 1;
      step("rw_again");
      hz.mem_ready = 1;
      step("rw_rel");
      idle();

      for (int i = 0; i < 300; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         hz.id_rs = 5'($urandom_range(0, 3));
         hz.id_rt = 5'($urandom_range(0, 3));
         hz.id_uses_rs = 1'($urandom);
         hz.id_uses_rt = 1'($urandom);
         hz.ex_memread = 1'($urandom);
         hz.ex_wreg = 5'($urandom_range(0, 3));
         hz.ex_branch_tk = ($urandom_range(0, 5) == 0);
         hz.id_jump = ($urandom_range(0, 5) == 0);
         hz.mem_req = ($urandom_range(0, 3) == 0);
         hz.mem_ready = ($urandom_range(0, 3) == 0);
         hz.exc_ex = ($urandom_range(0, 15) == 0);
         hz.irq = ($urandom_range(0, 15) == 0);
         step("rnd");
      end
      idle();
      chk_perf("end_perf");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
